mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the single external memory port of the single-cycle computer and shares it between the instruction-fetch requester and the load/store data requester. Each requester uses a req/done handshake. The arbiter issues one memory transaction at a time on a valid/ready port and returns read data with a registered done pulse. It asserts `stall` so the PC/register state holds while any access is outstanding. A starvation limit and a wait-state watchdog bound the latency of every request.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_STREAK`, 3, consecutive data grants allowed while a fetch is waiting
- `TIMEOUT`, 15, max cycles to wait for `mem_ready` before aborting (≥1)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held with `if_addr` until `if_done`
- `if_addr`  in  ADDR_W  fetch address (PC)
- `if_rdata`  out  DATA_W  fetched instruction, valid while `if_done`=1
- `if_done`  out  1  one-cycle completion pulse
- `d_req`  in  1  data request; held with the `d_*` fields until `d_done`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_be`  in  DATA_W/8  byte enables
- `d_rdata`  out  DATA_W  load data, valid while `d_done`=1
- `d_done`  out  1  one-cycle completion pulse
- `mem_valid`  out  1  transaction request to memory
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/ADDR_W/DATA_W/DATA_W/8  transaction fields
- `mem_ready`  in  1  memory accepts/completes transaction this cycle
- `mem_rdata`  in  DATA_W  read data, valid when `mem_valid & mem_ready`
- `bus_err`  out  1  qualifies `if_done`/`d_done`: the access timed out
- `stall`  out  1  combinational: `if_req | d_req` and no done pulse this cycle

## Operation
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE:
  - If `d_req` and (`!if_req` or `streak < MAX_STREAK`): latch the `d_*` fields and go to DATA.
  - Else if `if_req`: latch `if_addr` and go to FETCH.
  - Else stay in IDLE.
- FETCH/DATA:
  - `mem_valid`=1 with the latched fields; `mem_we`=0 in FETCH.
  - On `mem_ready`: capture `mem_rdata`, go to RESP, set the matching done.
  - On wait-counter = `TIMEOUT` with no ready: drop `mem_valid`, go to RESP, set done and `bus_err`; rdata is 0.
- RESP: exactly one of `if_done`/`d_done` is high. No requests are sampled. Return to IDLE.
- Streak counter, width $clog2(MAX_STREAK+1):
  - Increments (saturating) on a data grant made while `if_req`=1.
  - Cleared on a fetch grant.
  - Cleared on a data grant with `if_req`=0.
- Stores return `d_rdata`=0.
- Requester fields change between grant and done: ignored, because the fields are latched at grant.
- Requester drops `req` before done: the transaction still completes, and done still pulses.
- `mem_ready` while `mem_valid`=0: ignored.
- Reset (any time, including mid-transaction):
  - State IDLE, streak 0, wait counter 0.
  - All outputs 0.
  - The in-flight access is lost; the requester must re-issue.

## Timing
- All outputs are registered except `stall`.
- Grant: request sampled in IDLE at edge N → `mem_valid` high from cycle N+1.
- Zero-wait memory: `mem_ready` in cycle N+1 → done pulse in cycle N+2 → IDLE in N+3. Minimum latency is 2 cycles from request to done; throughput is one access per 3 cycles.
- Each wait state adds 1 cycle. Worst-case data latency is 2+`TIMEOUT` cycles.
- Worst-case fetch latency is (`MAX_STREAK`+1)·(3+`TIMEOUT`) cycles.
- Wait counter: resets to 0 at grant and increments each cycle `mem_valid & !mem_ready`. Timeout fires in the cycle the count equals `TIMEOUT`.
- Back-to-back: a requester may keep `req` high after done with new fields. It is arbitrated in the IDLE cycle that follows RESP.

## Structure
- Shared package `scc_mem_pkg`:
  - `arb_state_t` enum.
  - `ADDR_W`/`DATA_W` defaults.
  - Byte-enable width function.
- Single module. No sub-module; the priority logic is a small function inside the module.

## Test plan
- Lone fetch, `if_addr`=0x0000_0010, `mem_ready` tied 1, `mem_rdata`=0xE3A0_0001 → `mem_valid` cycle 1, `if_done` and `if_rdata`=0xE3A0_0001 in cycle 2, `stall` low in cycle 2.
- Simultaneous `if_req` and `d_req` (load 0x100) every cycle, `MAX_STREAK`=3 → grant order D,D,D,F,D,D,D,F.
- Store 0xDEAD_BEEF to 0x200, `d_be`=0xF, `mem_ready` after 4 wait cycles → `mem_we`=1 with stable fields for 5 cycles, `d_done` 1 cycle after ready, `d_rdata`=0.
- `mem_ready` never asserted, `TIMEOUT`=15 → `mem_valid` high 16 cycles, then `d_done` with `bus_err`=1, then IDLE.
- `reset` low in the 2nd wait cycle of a fetch → all outputs 0 immediately. After release, the held `if_req` is re-granted 1 cycle later.
- Requester changes `d_addr` to 0x300 after grant on 0x100 → `mem_addr` stays 0x100 until done.

Source files
------------

// File: rtl/scc_mem_pkg.sv
// rtl/scc_mem_pkg.sv - shared types, widths and helpers for the memory port arbiter
package scc_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // One enable bit per byte lane of the data bus.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-port signal bundle for the arbiter
//
// Groups the fetch requester (if_*), data requester (d_*), the external
// memory port (mem_*), bus_err and stall.
//   slave  : arbiter view (requests and memory responses in, grants out)
//   master : environment view (core + memory model)
interface mem_port_arbiter_if
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int BE_W = be_width(DATA_W);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              bus_err;
    logic              stall;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_done,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata,
        output bus_err, stall
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_done,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_done,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata,
        input  bus_err, stall
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (requesters, memory port, bus_err, stall)
// One transaction in flight at a time: IDLE -> FETCH/DATA -> RESP -> IDLE.
// Data wins arbitration unless a waiting fetch has already been passed over
// MAX_STREAK times; a watchdog aborts any access after TIMEOUT wait states.
module mem_port_arbiter
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STREAK = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int BE_W     = be_width(DATA_W);
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [STREAK_W-1:0] r_streak;
    logic [WAIT_W-1:0]   r_wait;

    logic                r_mem_valid;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [BE_W-1:0]     r_mem_be;
    logic                r_if_done;
    logic                r_d_done;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_bus_err;

    logic                w_grant_d;
    logic                w_grant_f;
    logic                w_mem_hit;
    logic                w_timeout;
    logic                w_mem_valid_nxt;
    logic                w_if_done_nxt;
    logic                w_d_done_nxt;
    logic                w_bus_err_nxt;

    // Data goes first unless a fetch is waiting and has been skipped MAX_STREAK times.
    function automatic logic pick_data(input logic d_req, input logic f_req,
                                       input logic [STREAK_W-1:0] streak);
        return d_req && (!f_req || (streak < STREAK_W'(MAX_STREAK)));
    endfunction

    assign w_grant_d = (r_state == ST_IDLE) && pick_data(bus.d_req, bus.if_req, r_streak);
    assign w_grant_f = (r_state == ST_IDLE) && bus.if_req && !w_grant_d;

    // mem_valid is high exactly in FETCH/DATA, so ready outside them is ignored.
    assign w_mem_hit = r_mem_valid && bus.mem_ready;
    assign w_timeout = r_mem_valid && !bus.mem_ready && (r_wait == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = ST_DATA;
                end else if (w_grant_f) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (w_mem_hit || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the transition taken.
    always_comb begin
        w_mem_valid_nxt = (w_next_state == ST_FETCH) || (w_next_state == ST_DATA);
        w_if_done_nxt   = (r_state == ST_FETCH) && (w_next_state == ST_RESP);
        w_d_done_nxt    = (r_state == ST_DATA)  && (w_next_state == ST_RESP);
        w_bus_err_nxt   = (w_if_done_nxt || w_d_done_nxt) && !w_mem_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_bus_err   <= 1'b0;
            r_streak    <= '0;
            r_wait      <= '0;
        end else begin
            r_mem_valid <= w_mem_valid_nxt;
            r_if_done   <= w_if_done_nxt;
            r_d_done    <= w_d_done_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_if_rdata  <= (w_if_done_nxt && w_mem_hit) ? bus.mem_rdata : '0;
            r_d_rdata   <= (w_d_done_nxt && w_mem_hit && !r_mem_we) ? bus.mem_rdata : '0;

            // Fields are latched at grant so requester changes mid-access are ignored.
            if (w_grant_d) begin
                r_mem_we    <= bus.d_we;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
                r_mem_be    <= bus.d_be;
            end else if (w_grant_f) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.if_addr;
                r_mem_wdata <= '0;
                r_mem_be    <= '1;
            end

            if (w_grant_d) begin
                if (!bus.if_req) begin
                    r_streak <= '0;
                end else if (r_streak != STREAK_W'(MAX_STREAK)) begin
                    r_streak <= r_streak + STREAK_W'(1);
                end
            end else if (w_grant_f) begin
                r_streak <= '0;
            end

            if (w_grant_d || w_grant_f) begin
                r_wait <= '0;
            end else if (r_mem_valid && !bus.mem_ready && !w_timeout) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.if_done   = r_if_done;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_done    = r_d_done;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.bus_err   = r_bus_err;

    // Held low during reset so every output reads 0 while reset is asserted.
    assign bus.stall = reset && (bus.if_req || bus.d_req) && !(r_if_done || r_d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_STREAK(3), .TIMEOUT(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
        bus.d_be      = 4'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_order;
        logic [7:0] got_order;
        int         ngrant;
        logic       prev_valid;
        int         nvalid;
        logic       seen_done;

        reset = 1'b0;
        idle_inputs();

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check_val("rst_if_done",   32'(bus.if_done),   32'd0);
        check_val("rst_d_done",    32'(bus.d_done),    32'd0);
        check_val("rst_bus_err",   32'(bus.bus_err),   32'd0);
        check_val("rst_mem_addr",  bus.mem_addr,       32'd0);
        check_val("rst_stall",     32'(bus.stall),     32'd0);
        reset = 1'b1;

        // mem_ready with nothing outstanding is ignored
        @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check_val("idle_ready_done", 32'({bus.if_done, bus.d_done, bus.mem_valid}), 32'd0);

        // Lone fetch, zero-wait memory
        @(negedge clk);
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_0010;
        bus.mem_rdata = 32'hE3A0_0001;
        #1;
        check_val("f_stall_req", 32'(bus.stall), 32'd1);
        @(negedge clk);
        check_val("f_mem_valid", 32'(bus.mem_valid), 32'd1);
        check_val("f_mem_we",    32'(bus.mem_we),    32'd0);
        check_val("f_mem_addr",  bus.mem_addr,       32'h0000_0010);
        check_val("f_if_done_early", 32'(bus.if_done), 32'd0);
        @(negedge clk);
        check_val("f_if_done",   32'(bus.if_done),   32'd1);
        check_val("f_if_rdata",  bus.if_rdata,       32'hE3A0_0001);
        check_val("f_bus_err",   32'(bus.bus_err),   32'd0);
        check_val("f_stall_done", 32'(bus.stall),    32'd0);
        check_val("f_mem_valid_off", 32'(bus.mem_valid), 32'd0);
        bus.if_req = 1'b0;
        @(negedge clk);
        check_val("f_if_done_pulse", 32'(bus.if_done), 32'd0);

        // Both requesters always asking: D,D,D,F,D,D,D,F
        bus.if_addr = 32'h0000_0020;
        bus.d_addr  = 32'h0000_0100;
        bus.d_we    = 1'b0;
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        exp_order   = 8'b0111_0111;
        got_order   = 8'h00;
        ngrant      = 0;
        prev_valid  = 1'b0;
        for (int c = 0; c < 40 && ngrant < 8; c++) begin
            @(negedge clk);
            if (bus.mem_valid && !prev_valid) begin
                got_order[ngrant] = (bus.mem_addr == 32'h0000_0100);
                ngrant++;
                if (ngrant == 8) begin
                    bus.if_req = 1'b0;
                    bus.d_req  = 1'b0;
                end
            end
            prev_valid = bus.mem_valid;
        end
        check_val("arb_grant_count", ngrant, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("arb_order_%0d", i), 32'(got_order[i]), 32'(exp_order[i]));
        end
        repeat (3) @(negedge clk);

        // Store with 4 wait states
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h1234_5678;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h0000_0200;
        bus.d_wdata   = 32'hDEAD_BEEF;
        bus.d_be      = 4'hF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check_val($sformatf("st_valid_%0d", c), 32'(bus.mem_valid), 32'd1);
            check_val($sformatf("st_fields_%0d", c),
                      32'({bus.mem_we, bus.mem_be}), 32'h1F);
            check_val($sformatf("st_addr_%0d", c),  bus.mem_addr,  32'h0000_0200);
            check_val($sformatf("st_wdata_%0d", c), bus.mem_wdata, 32'hDEAD_BEEF);
            check_val($sformatf("st_done_%0d", c),  32'(bus.d_done), 32'd0);
            if (c == 5) bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        check_val("st_d_done",  32'(bus.d_done), 32'd1);
        check_val("st_d_rdata", bus.d_rdata,     32'h0);
        check_val("st_bus_err", 32'(bus.bus_err), 32'd0);
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Memory never ready: watchdog abort after 16 valid cycles
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0100;
        nvalid     = 0;
        seen_done  = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(negedge clk);
            if (bus.mem_valid) nvalid++;
            if (bus.d_done) seen_done = 1'b1;
        end
        check_val("to_done_seen", 32'(seen_done), 32'd1);
        check_val("to_valid_cycles", nvalid, 32'd16);
        check_val("to_bus_err", 32'(bus.bus_err), 32'd1);
        check_val("to_d_rdata", bus.d_rdata, 32'h0);
        bus.d_req = 1'b0;
        @(negedge clk);
        check_val("to_idle", 32'({bus.mem_valid, bus.d_done, bus.bus_err}), 32'd0);
        @(negedge clk);

        // Reset during the second wait cycle of a fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        @(negedge clk);
        check_val("rs_wait1_valid", 32'(bus.mem_valid), 32'd1);
        @(negedge clk);
        check_val("rs_wait2_valid", 32'(bus.mem_valid), 32'd1);
        reset = 1'b0;
        #1;
        check_val("rs_mem_valid", 32'(bus.mem_valid), 32'd0);
        check_val("rs_mem_addr",  bus.mem_addr,       32'd0);
        check_val("rs_stall",     32'(bus.stall),     32'd0);
        check_val("rs_dones",     32'({bus.if_done, bus.d_done, bus.bus_err}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rs_regrant_valid", 32'(bus.mem_valid), 32'd1);
        check_val("rs_regrant_addr",  bus.mem_addr,       32'h0000_0040);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hA5A5_0003;
        @(negedge clk);
        check_val("rs_if_done",  32'(bus.if_done), 32'd1);
        check_val("rs_if_rdata", bus.if_rdata,     32'hA5A5_0003);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Requester changes d_addr after grant: latched address holds
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0100;
        @(negedge clk);
        bus.d_addr = 32'h0000_0300;
        for (int c = 1; c <= 3; c++) begin
            check_val($sformatf("fc_addr_%0d", c), bus.mem_addr, 32'h0000_0100);
            if (c == 3) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hCAFE_0001;
            end
            @(negedge clk);
        end
        check_val("fc_d_done",  32'(bus.d_done), 32'd1);
        check_val("fc_d_rdata", bus.d_rdata,     32'hCAFE_0001);
        check_val("fc_addr_done", bus.mem_addr,  32'h0000_0100);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
